hazard_scoreboard: RTL



---
 rtl/hazard_scoreboard.sv | 112 +++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard for pending writes; drives the ID-stage stall and, when
// built with HAZARD_FWD_EN, per-source bypass selects so dependents wait only for the bypass point.
module hazard_scoreboard #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned LAT_W  = 3,
    parameter int unsigned PERF_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     src1_used,
    input  logic [ADDR_W-1:0]        src1,
    input  logic                     src2_used,
    input  logic [ADDR_W-1:0]        src2,
    input  logic                     issue_valid,
    input  logic                     issue_wr,
    input  logic [ADDR_W-1:0]        issue_dst,
    input  logic [LAT_W-1:0]         issue_lat,
    input  logic                     wb_valid,
    input  logic [ADDR_W-1:0]        wb_dst,
    output logic                     stall,
    output logic                     fwd1,
    output logic                     fwd2,
    output logic [(2**ADDR_W)-1:0]   busy,
    output logic [PERF_W-1:0]        stall_cycles
);

    localparam int unsigned NUM_REGS = 2**ADDR_W;

    logic [LAT_W-1:0]  cnt_q [NUM_REGS];
    logic [LAT_W-1:0]  cnt_d [NUM_REGS];
    logic [PERF_W-1:0] stall_cycles_q;
    logic [PERF_W-1:0] stall_cycles_d;

    logic              hit1;
    logic              hit2;
    logic [LAT_W-1:0]  cnt_src1;
    logic [LAT_W-1:0]  cnt_src2;
    logic              wait1;
    logic              wait2;
    logic              issue_fire;

    // Hazard detection on the two ID-stage sources; register 0 never participates
    always_comb begin
        hit1     = src1_used && (src1 != '0);
        hit2     = src2_used && (src2 != '0);
        cnt_src1 = cnt_q[src1];
        cnt_src2 = cnt_q[src2];
`ifdef HAZARD_FWD_EN
        wait1 = hit1 && (cnt_src1 > LAT_W'(1));
        wait2 = hit2 && (cnt_src2 > LAT_W'(1));
        stall = wait1 || wait2;
        fwd1  = hit1 && (cnt_src1 == LAT_W'(1)) && !stall;
        fwd2  = hit2 && (cnt_src2 == LAT_W'(1)) && !stall;
`else
        wait1 = hit1 && (cnt_src1 != '0);
        wait2 = hit2 && (cnt_src2 != '0);
        stall = wait1 || wait2;
        fwd1  = 1'b0;
        fwd2  = 1'b0;
`endif
        issue_fire = issue_valid && !stall && !flush;
    end

    // Next counter values: flush, then issue (WAW beats early writeback), then writeback, then countdown
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r == 0) begin
                cnt_d[r] = '0;
            end else if (flush) begin
                cnt_d[r] = '0;
            end else if (issue_fire && issue_wr && (issue_dst == ADDR_W'(r))) begin
                cnt_d[r] = issue_lat;
            end else if (wb_valid && (wb_dst == ADDR_W'(r))) begin
                cnt_d[r] = '0;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - LAT_W'(1);
            end
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && !flush && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + PERF_W'(1);
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            busy[r] = (cnt_q[r] != '0);
        end
    end

    assign stall_cycles = stall_cycles_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cycles_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_cycles_q <= stall_cycles_d;
        end
    end

endmodule
